// File: rtl/byte_pkg.sv
// ============================================================================
// byte_pkg : shared constants and helpers for the byte write buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package byte_pkg;

  localparam logic c_LOCK_FREE = 1'b0;
  localparam logic c_LOCK_HELD = 1'b1;

  function automatic logic [63:0] word_addr(input logic [63:0] addr,
                                            input int unsigned shift);
    return addr >> shift;
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_write_fifo.sv
// ============================================================================
// byte_write_fifo : register-based FIFO of posted writes {addr, mask, data}.
// BYTE_WRITE_BUFFER_BYPASS_EN adds entry/valid exposure for read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_write_fifo
  import byte_pkg::*;
#(
  parameter int unsigned DATA_BYTE = 4,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_SIZE-1:0]         push_addr_i,
  input  logic [DATA_BYTE-1:0]         push_mask_i,
  input  logic [DATA_BYTE*8-1:0]       push_data_i,
  output logic [ADDR_SIZE-1:0]         head_addr_o,
  output logic [DATA_BYTE-1:0]         head_mask_o,
  output logic [DATA_BYTE*8-1:0]       head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
  ,
  output logic [DEPTH-1:0][ADDR_SIZE-1:0] entry_addr_o,
  output logic [DEPTH-1:0]                entry_valid_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_SIZE-1:0]   addr_q [DEPTH];
  logic [DATA_BYTE-1:0]   mask_q [DEPTH];
  logic [DATA_BYTE*8-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: an entry is only observable once counted.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      mask_q[wr_ptr_q] <= push_mask_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_mask_o = mask_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] w_offset;
    assign w_offset         = PW'(i) - rd_ptr_q;
    assign entry_addr_o[i]  = addr_q[i];
    assign entry_valid_o[i] = ({1'b0, w_offset} < count_q);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/byte_write_buffer.sv
// ============================================================================
// byte_write_buffer : posted-write buffer between a byte bus and memory.
// BYTE_WRITE_BUFFER_BYPASS_EN lets non-conflicting reads overtake the drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_write_buffer
  import byte_pkg::*;
#(
  parameter int unsigned DATA_BYTE = 4,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       upEnable_i,
  input  logic                       upIsWrite_i,
  input  logic [DATA_BYTE-1:0]       upWriteMask_i,
  input  logic [ADDR_SIZE-1:0]       upAddr_i,
  input  logic [DATA_BYTE*8-1:0]     upWriteData_i,
  output logic [DATA_BYTE*8-1:0]     upReadData_o,
  output logic                       upHold_o,
  output logic                       memEnable_o,
  output logic                       memIsWrite_o,
  output logic [DATA_BYTE-1:0]       memWriteMask_o,
  output logic [ADDR_SIZE-1:0]       memAddr_o,
  output logic [DATA_BYTE*8-1:0]     memWriteData_o,
  input  logic [DATA_BYTE*8-1:0]     memReadData_i,
  input  logic                       memHold_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam bit c_DEPTH_OK = depth_legal(DEPTH);

  if (!c_DEPTH_OK) begin : g_depth_check
    $error("byte_write_buffer: DEPTH must be a power of two and >= 2");
  end

  logic                   w_full, w_empty;
  logic                   w_push, w_pop;
  logic                   w_rd_req, w_bypass, w_drain, w_rd_issue;
  logic [ADDR_SIZE-1:0]   w_head_addr;
  logic [DATA_BYTE-1:0]   w_head_mask;
  logic [DATA_BYTE*8-1:0] w_head_data;
  logic                   lock_q, lock_d;

`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
  localparam int unsigned c_SHIFT = $clog2(DATA_BYTE);
  logic [DEPTH-1:0][ADDR_SIZE-1:0] w_entry_addr;
  logic [DEPTH-1:0]                w_entry_valid;
  logic                            w_match;
`endif

  byte_write_fifo #(
    .DATA_BYTE (DATA_BYTE),
    .ADDR_SIZE (ADDR_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (w_push),
    .pop_i         (w_pop),
    .push_addr_i   (upAddr_i),
    .push_mask_i   (upWriteMask_i),
    .push_data_i   (upWriteData_i),
    .head_addr_o   (w_head_addr),
    .head_mask_o   (w_head_mask),
    .head_data_o   (w_head_data),
    .full_o        (w_full),
    .empty_o       (w_empty),
    .count_o       (count_o)
`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
    ,
    .entry_addr_o  (w_entry_addr),
    .entry_valid_o (w_entry_valid)
`endif
  );

  // Full is judged on the registered count, so a same-cycle pop never admits a write.
  assign w_push   = upEnable_i & upIsWrite_i & ~w_full;
  assign w_rd_req = upEnable_i & ~upIsWrite_i;

`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] &&
          (word_addr(64'(w_entry_addr[i]), c_SHIFT) == word_addr(64'(upAddr_i), c_SHIFT)))
        w_match = 1'b1;
    end
  end
  assign w_bypass = w_rd_req & ~w_empty & ~w_match;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_drain    = ~w_empty & (lock_q | ~w_bypass);
  assign w_rd_issue = w_rd_req & ~w_drain & (w_empty | w_bypass);
  assign w_pop      = w_drain & ~memHold_i;

  // Drain lock: a presented-but-stalled drain may not be preempted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lock_q <= c_LOCK_FREE;
    else        lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      c_LOCK_FREE: if (w_drain && memHold_i)  lock_d = c_LOCK_HELD;
      c_LOCK_HELD: if (!memHold_i)            lock_d = c_LOCK_FREE;
      default:                                lock_d = c_LOCK_FREE;
    endcase
  end

  always_comb begin
    memEnable_o    = 1'b0;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    if (w_drain) begin
      memEnable_o    = 1'b1;
      memIsWrite_o   = 1'b1;
      memWriteMask_o = w_head_mask;
      memAddr_o      = w_head_addr;
      memWriteData_o = w_head_data;
    end else if (w_rd_issue) begin
      memEnable_o    = 1'b1;
      memIsWrite_o   = 1'b0;
      memWriteMask_o = upWriteMask_i;
      memAddr_o      = upAddr_i;
      memWriteData_o = upWriteData_i;
    end
  end

  always_comb begin
    upHold_o = 1'b0;
    if (upEnable_i) begin
      if (upIsWrite_i) upHold_o = w_full;
      else             upHold_o = w_rd_issue ? memHold_i : 1'b1;
    end
  end

  assign upReadData_o = memReadData_i;
  assign empty_o      = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_byte_write_buffer.sv
// ============================================================================
// tb_byte_write_buffer : directed self-checking bench for byte_write_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_byte_write_buffer;

  localparam int DB = 4;
  localparam int AS = 32;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            upEnable_i, upIsWrite_i;
  logic [DB-1:0]   upWriteMask_i;
  logic [AS-1:0]   upAddr_i;
  logic [DB*8-1:0] upWriteData_i, upReadData_o;
  logic            upHold_o;
  logic            memEnable_o, memIsWrite_o;
  logic [DB-1:0]   memWriteMask_o;
  logic [AS-1:0]   memAddr_o;
  logic [DB*8-1:0] memWriteData_o, memReadData_i;
  logic            memHold_i;
  logic [CW-1:0]   count_o;
  logic            empty_o;

  always #5 clk_i = ~clk_i;

  byte_write_buffer #(.DATA_BYTE(DB), .ADDR_SIZE(AS), .DEPTH(DP)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .upEnable_i     (upEnable_i),
    .upIsWrite_i    (upIsWrite_i),
    .upWriteMask_i  (upWriteMask_i),
    .upAddr_i       (upAddr_i),
    .upWriteData_i  (upWriteData_i),
    .upReadData_o   (upReadData_o),
    .upHold_o       (upHold_o),
    .memEnable_o    (memEnable_o),
    .memIsWrite_o   (memIsWrite_o),
    .memWriteMask_o (memWriteMask_o),
    .memAddr_o      (memAddr_o),
    .memWriteData_o (memWriteData_o),
    .memReadData_i  (memReadData_i),
    .memHold_i      (memHold_i),
    .count_o        (count_o),
    .empty_o        (empty_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic up_write(input logic [AS-1:0] a, input logic [DB*8-1:0] d);
    upEnable_i    = 1'b1;
    upIsWrite_i   = 1'b1;
    upWriteMask_i = '1;
    upAddr_i      = a;
    upWriteData_i = d;
  endtask

  task automatic up_read(input logic [AS-1:0] a);
    upEnable_i    = 1'b1;
    upIsWrite_i   = 1'b0;
    upWriteMask_i = '0;
    upAddr_i      = a;
    upWriteData_i = '0;
  endtask

  task automatic up_idle();
    upEnable_i    = 1'b0;
    upIsWrite_i   = 1'b0;
    upWriteMask_i = '0;
    upAddr_i      = '0;
    upWriteData_i = '0;
  endtask

  initial begin
    rst_i         = 1'b0;
    memHold_i     = 1'b1;
    memReadData_i = '0;
    up_idle();
    #2;
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_empty", 64'(empty_o), 64'd1);
    check_eq("rst_memen", 64'(memEnable_o), 64'd0);
    check_eq("rst_hold",  64'(upHold_o), 64'd0);
    repeat (2) tick();
    rst_i = 1'b1;

    // Fill the buffer against a stalled memory.
    for (int i = 0; i < 4; i++) begin
      up_write(AS'(4 * i), 32'h1111_0000 + 32'(i));
      settle();
      check_eq("fill_hold", 64'(upHold_o), 64'd0);
      if (i > 0) begin
        check_eq("fill_memen", 64'(memEnable_o), 64'd1);
        check_eq("fill_head",  64'(memAddr_o), 64'h0);
      end
      tick();
    end
    up_write(32'h10, 32'hAABB_0010);
    settle();
    check_eq("full_hold",  64'(upHold_o), 64'd1);
    check_eq("full_count", 64'(count_o), 64'd4);
    tick();
    check_eq("full_hold2", 64'(upHold_o), 64'd1);

    // Release: pop does not free a slot for the same-cycle write.
    memHold_i = 1'b0;
    settle();
    check_eq("pop_full_hold", 64'(upHold_o), 64'd1);
    check_eq("drain0", 64'(memAddr_o), 64'h0);
    tick();
    check_eq("late_accept", 64'(upHold_o), 64'd0);
    check_eq("drain1", 64'(memAddr_o), 64'h4);
    check_eq("cnt3", 64'(count_o), 64'd3);
    tick();
    up_idle();
    settle();
    check_eq("push_pop_cnt", 64'(count_o), 64'd3);
    check_eq("drain2", 64'(memAddr_o), 64'h8);
    tick();
    check_eq("drain3", 64'(memAddr_o), 64'hC);
    tick();
    check_eq("drain4", 64'(memAddr_o), 64'h10);
    check_eq("drain4_data", 64'(memWriteData_o), 64'hAABB_0010);
    check_eq("drain4_wr", 64'(memIsWrite_o), 64'd1);
    tick();
    check_eq("drained_cnt", 64'(count_o), 64'd0);
    check_eq("drained_empty", 64'(empty_o), 64'd1);
    check_eq("idle_memen", 64'(memEnable_o), 64'd0);

    // Read after write waits for the buffer to empty.
    up_write(32'h10, 32'hAABB_CCDD);
    settle();
    check_eq("post_hold", 64'(upHold_o), 64'd0);
    check_eq("post_no_mem", 64'(memEnable_o), 64'd0);
    tick();
    up_read(32'h10);
    settle();
    check_eq("raw_hold", 64'(upHold_o), 64'd1);
    check_eq("raw_drain_wr", 64'(memIsWrite_o), 64'd1);
    check_eq("raw_drain_data", 64'(memWriteData_o), 64'hAABB_CCDD);
    tick();
    check_eq("rd_empty", 64'(empty_o), 64'd1);
    check_eq("rd_memen", 64'(memEnable_o), 64'd1);
    check_eq("rd_iswr", 64'(memIsWrite_o), 64'd0);
    check_eq("rd_addr", 64'(memAddr_o), 64'h10);
    check_eq("rd_hold", 64'(upHold_o), 64'd0);
    memReadData_i = 32'hAABB_CCDD;
    settle();
    check_eq("rd_data", 64'(upReadData_o), 64'hAABB_CCDD);
    memHold_i = 1'b1;
    settle();
    check_eq("rd_memhold", 64'(upHold_o), 64'd1);
    memHold_i = 1'b0;
    tick();
    up_idle();

    // Locked drain versus a non-matching read.
    memHold_i = 1'b1;
    up_write(32'h20, 32'h2020_2020);
    tick();
    up_write(32'h30, 32'h3030_3030);
    settle();
    check_eq("lock_pres", 64'(memAddr_o), 64'h20);
    tick();
    up_read(32'h40);
    settle();
    check_eq("lock_addr", 64'(memAddr_o), 64'h20);
    check_eq("lock_wr", 64'(memIsWrite_o), 64'd1);
    check_eq("lock_rdhold", 64'(upHold_o), 64'd1);
    memHold_i = 1'b0;
    settle();
    check_eq("lock_accept", 64'(memAddr_o), 64'h20);
    tick();
`ifdef BYTE_WRITE_BUFFER_BYPASS_EN
    check_eq("byp_iswr", 64'(memIsWrite_o), 64'd0);
    check_eq("byp_addr", 64'(memAddr_o), 64'h40);
    check_eq("byp_hold", 64'(upHold_o), 64'd0);
    check_eq("byp_cnt", 64'(count_o), 64'd1);
    tick();
    up_idle();
    settle();
    check_eq("byp_after", 64'(memAddr_o), 64'h30);
    tick();
`else
    check_eq("nobyp_addr", 64'(memAddr_o), 64'h30);
    check_eq("nobyp_hold", 64'(upHold_o), 64'd1);
    tick();
    check_eq("nobyp_rd_iswr", 64'(memIsWrite_o), 64'd0);
    check_eq("nobyp_rd_addr", 64'(memAddr_o), 64'h40);
    check_eq("nobyp_rd_hold", 64'(upHold_o), 64'd0);
    tick();
    up_idle();
`endif

    // A read to a buffered word waits for empty in either build.
    up_write(32'h20, 32'h2121_2121);
    tick();
    up_read(32'h22);
    settle();
    check_eq("match_drain", 64'(memAddr_o), 64'h20);
    check_eq("match_wr", 64'(memIsWrite_o), 64'd1);
    check_eq("match_hold", 64'(upHold_o), 64'd1);
    tick();
    check_eq("match_rd_addr", 64'(memAddr_o), 64'h22);
    check_eq("match_rd_iswr", 64'(memIsWrite_o), 64'd0);
    check_eq("match_rd_hold", 64'(upHold_o), 64'd0);
    tick();
    up_idle();

    // Reset mid-operation discards buffered writes.
    memHold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_write(AS'(32'h50 + 4 * i), 32'h5050_0000 + 32'(i));
      tick();
    end
    up_idle();
    settle();
    check_eq("pre_rst_cnt", 64'(count_o), 64'd3);
    rst_i = 1'b0;
    settle();
    check_eq("arst_cnt", 64'(count_o), 64'd0);
    check_eq("arst_empty", 64'(empty_o), 64'd1);
    check_eq("arst_memen", 64'(memEnable_o), 64'd0);
    tick();
    rst_i     = 1'b1;
    memHold_i = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      check_eq("post_rst_idle", 64'(memEnable_o), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_write_buffer.md
# byte_write_buffer

Posted-write buffer between a byte-bus master (typically the output of a byte-memory mux) and a byte-addressed memory. Upstream writes enter a small FIFO and complete without waiting for the memory. Buffered writes drain to the memory in order. Reads are held back until ordering against buffered writes is guaranteed.

## Interface
Parameters:
- DATA_BYTE, 4, data bytes per word
- ADDR_SIZE, 32, byte address width
- DEPTH, 4, buffer entries; power of two, ≥2

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- upEnable_i  in  1  upstream request valid
- upIsWrite_i  in  1  1 = write, 0 = read
- upWriteMask_i  in  DATA_BYTE  byte enables
- upAddr_i  in  ADDR_SIZE  byte address
- upWriteData_i  in  DATA_BYTE*8  write data
- upReadData_o  out  DATA_BYTE*8  read data
- upHold_o  out  1  request not accepted this cycle
- memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o  out  (as upstream)  memory request
- memReadData_i  in  DATA_BYTE*8  memory read data
- memHold_i  in  1  memory stall
- count_o  out  $clog2(DEPTH+1)  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Bus rule: a request is accepted in any cycle with enable=1 and hold=0. The requester keeps its request stable while held.
- upHold_o = 0 whenever upEnable_i = 0.
- Write, buffer not full: enqueued {addr, mask, data}, upHold_o = 0. Zero-mask writes are enqueued normally.
- Write, buffer full: upHold_o = 1. A pop in the same cycle does not free a slot for that write.
- Drain: while count_o > 0, the memory side presents the head entry (memIsWrite_o = 1). The entry pops when !memHold_i.
- Drain lock: once a drain is presented and held, a lock register keeps it presented until it is accepted.
- Read, buffer empty: passed through combinationally to the mem outputs; upHold_o = memHold_i.
- Read, buffer non-empty: upHold_o = 1 and the memory side keeps draining.
- upReadData_o = memReadData_i, unmodified.
- Push and pop in the same cycle: count unchanged.
- Idle (empty, no upstream read): memEnable_o = 0, other mem outputs don't-care (driven 0).

## Timing
- Reset state: count 0, pointers 0, lock 0. Combinational outputs follow their inputs during reset (empty path).
- Reset mid-operation: all buffered writes are discarded.
- Write latency: upstream completion takes 0 extra cycles. The entry reaches memEnable_o no earlier than the cycle after enqueue (FIFO output is registered).
- Read latency: none added; read data follows memory timing relative to the memory-side accept.
- Drain throughput: 1 entry/cycle while memHold_i = 0.

## Configuration
- BYTE_WRITE_BUFFER_BYPASS_EN defined: a read whose word address (addr[ADDR_SIZE-1:$clog2(DATA_BYTE)]) matches no valid entry gets memory priority over the drain, unless the drain lock is set. A matching read waits until the buffer is empty.
- Not defined: every read waits for empty; no address comparators are built.

## Structure
- Package byte_pkg:
  - word-address helper function (drops $clog2(DATA_BYTE) LSBs)
  - DEPTH-legality check constant
- Sub-module byte_write_fifo: register-based FIFO.
  - Interfaces: push/pop/full/empty/count, head entry.
  - Exposes all entries plus a valid vector for the bypass comparators.
- Top level: bus muxing, hold logic, drain lock.

## Test plan
1. DEPTH=4, memHold_i=1, five back-to-back writes to 0x0,0x4,0x8,0xC,0x10 -> first four see upHold_o=0; fifth sees upHold_o=1; count_o=4.
2. Release memHold_i from state 1 -> memAddr_o = 0x0,0x4,0x8,0xC on consecutive cycles. The fifth write is then accepted. count_o ends at 0 after 0x10 drains.
3. Write 0x10 = 0xAABBCCDD, then read 0x10 next cycle (no bypass macro):
   - read is held until empty_o=1, then issued to memory
   - upReadData_o equals memReadData_i
4. Macro defined, write 0x20 buffered with memHold_i=1 for one cycle:
   - read 0x40 is issued only after the locked drain is accepted, ahead of further entries
   - read 0x22 waits for empty
5. count_o=3, push and pop in the same cycle -> count_o stays 3; entry order is preserved at the memory.
6. Assert rst_i low with count_o=3 and upEnable_i=0 -> count_o=0, empty_o=1, memEnable_o=0 immediately; no buffered write reaches memory after release.
